// File: rtl/qmac_accum.sv
// Frame accumulator for sign-magnitude Q-format products.
// Saturating two's-complement sum with guard bits, sign-magnitude result.
module qmac_accum #(
  parameter int N     = 32,
  parameter int G     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_product,
  input  logic             i_ovr,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_res_ready,
  output logic [N-1:0]     o_result,
  output logic             o_ovr,
  output logic [CNT_W-1:0] o_terms
);

  localparam int A = N + G;
  localparam logic signed [A:0] SMAX = {2'b00, {(A-1){1'b1}}};
  localparam logic signed [A:0] SMIN = -SMAX;
  localparam logic [A-1:0] OMAX = {{(G+1){1'b0}}, {(N-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t state_q, state_d;

  logic signed [A-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    terms_q, terms_d;
  logic                ovr_q, ovr_d;
  logic [N-1:0]        res_q, res_d;

  logic                beat;
  logic [A-1:0]        mag_ext;
  logic signed [A-1:0] conv_w;
  logic signed [A:0]   sum_w;
  logic                sat_hit;
  logic [A-1:0]        acc_abs;

  assign beat    = i_valid && o_ready;
  assign mag_ext = {{(G+1){1'b0}}, i_product[N-2:0]};
  // negating a zero magnitude yields +0, so -0 needs no special case
  assign conv_w  = i_product[N-1] ? -$signed(mag_ext) : $signed(mag_ext);
  assign sum_w   = {acc_q[A-1], acc_q} + {conv_w[A-1], conv_w};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      terms_q <= '0;
      ovr_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      terms_q <= terms_d;
      ovr_q   <= ovr_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (beat) state_d = i_last ? DONE : ACC;
      end
      ACC: begin
        if (beat && i_last) state_d = DONE;
      end
      DONE: begin
        if (i_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready  = (state_q != DONE);
    o_valid  = (state_q == DONE);
    o_result = res_q;
    o_ovr    = ovr_q;
    o_terms  = terms_q;
  end

  always_comb begin
    acc_d   = acc_q;
    terms_d = terms_q;
    ovr_d   = ovr_q;
    res_d   = res_q;
    sat_hit = 1'b0;
    acc_abs = '0;
    if (beat) begin
      if (state_q == IDLE) begin
        acc_d   = conv_w;
        terms_d = CNT_W'(1);
        ovr_d   = i_ovr;
      end else begin
        if (sum_w > SMAX) begin
          acc_d   = SMAX[A-1:0];
          sat_hit = 1'b1;
        end else if (sum_w < SMIN) begin
          acc_d   = SMIN[A-1:0];
          sat_hit = 1'b1;
        end else begin
          acc_d   = sum_w[A-1:0];
        end
        if (terms_q != '1) terms_d = terms_q + CNT_W'(1);
        ovr_d = ovr_q | i_ovr | sat_hit;
      end
      if (i_last) begin
        acc_abs = acc_d[A-1] ? -acc_d : acc_d;
        if (acc_abs > OMAX) begin
          res_d = {acc_d[A-1], {(N-1){1'b1}}};
          ovr_d = 1'b1;
        end else begin
          res_d = {acc_d[A-1], acc_abs[N-2:0]};
        end
      end
    end
  end

endmodule

// File: tb/tb_qmac_accum.sv
// Scoreboard bench for qmac_accum.
// Directed frames push constants, mixed frames push a behavioural model.
module tb_qmac_accum;

  typedef struct packed {
    logic [31:0] res;
    logic        ovr;
    logic [7:0]  terms;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_product = '0;
  logic        i_ovr = 1'b0;
  logic        i_last = 1'b0;
  logic        o_valid;
  logic        i_res_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_ovr;
  logic [7:0]  o_terms;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  logic [31:0] fb[$];

  qmac_accum #(.N(32), .G(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_product(i_product), .i_ovr(i_ovr), .i_last(i_last),
    .o_valid(o_valid), .i_res_ready(i_res_ready),
    .o_result(o_result), .o_ovr(o_ovr), .o_terms(o_terms)
  );

  always #5 clk = ~clk;

  function automatic exp_t model();
    longint lim = (longint'(1) << 35) - 1;
    longint acc = 0;
    longint v;
    longint mag;
    exp_t e;
    int t = 0;
    bit ov = 1'b0;
    foreach (fb[i]) begin
      v = longint'(fb[i][30:0]);
      if (fb[i][31]) v = -v;
      if (i == 0) acc = v;
      else begin
        acc = acc + v;
        if (acc > lim) begin acc = lim; ov = 1'b1; end
        if (acc < -lim) begin acc = -lim; ov = 1'b1; end
      end
      t = (t < 255) ? t + 1 : 255;
    end
    mag = (acc < 0) ? -acc : acc;
    if (mag > 64'sd2147483647) begin
      e.res = {(acc < 0), 31'h7FFFFFFF};
      ov = 1'b1;
    end else begin
      e.res = {(acc < 0), mag[30:0]};
    end
    e.ovr = ov;
    e.terms = t[7:0];
    return e;
  endfunction

  task automatic send(input logic [31:0] p, input logic ov, input logic last);
    @(negedge clk);
    i_valid = 1'b1; i_product = p; i_ovr = ov; i_last = last;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_ovr = 1'b0; i_last = 1'b0;
  endtask

  task automatic push(input logic [31:0] r, input logic ov, input logic [7:0] t);
    exp_t e;
    e.res = r; e.ovr = ov; e.terms = t;
    sb.push_back(e);
  endtask

  // result must already be valid one cycle after the last beat
  task automatic collect(input string name);
    exp_t e;
    vectors++;
    if (o_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s latency: o_valid=%b queued=%0d want o_valid=1",
               name, o_valid, sb.size());
    end else begin
      e = sb.pop_front();
      vectors++;
      if (o_result !== e.res) begin
        miscompares++;
        $display("FAIL %s result: got %h want %h", name, o_result, e.res);
      end
      vectors++;
      if (o_ovr !== e.ovr) begin
        miscompares++;
        $display("FAIL %s ovr: got %b want %b", name, o_ovr, e.ovr);
      end
      vectors++;
      if (o_terms !== e.terms) begin
        miscompares++;
        $display("FAIL %s terms: got %0d want %0d", name, o_terms, e.terms);
      end
    end
    @(negedge clk);
    i_res_ready = 1'b1;
    @(posedge clk);
    #1;
    i_res_ready = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s release: o_valid=%b o_ready=%b want 0/1",
               name, o_valid, o_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({o_valid, o_ready, o_result, o_ovr, o_terms} !== {1'b0, 1'b1, 32'h0, 1'b0, 8'h0}) begin
      miscompares++;
      $display("FAIL reset: valid=%b ready=%b res=%h ovr=%b terms=%0d want 0 1 0 0 0",
               o_valid, o_ready, o_result, o_ovr, o_terms);
    end
  endtask

  task automatic test_sign_change();
    push(32'h00006000, 1'b0, 8'd3);
    send(32'h00008000, 1'b0, 1'b0);
    send(32'h80004000, 1'b0, 1'b0);
    send(32'h00002000, 1'b0, 1'b1);
    collect("sign_change");
  endtask

  task automatic test_negative();
    push(32'h80006000, 1'b0, 8'd2);
    send(32'h80008000, 1'b0, 1'b0);
    send(32'h00002000, 1'b0, 1'b1);
    collect("negative");
    push(32'h00000000, 1'b0, 8'd1);
    send(32'h80000000, 1'b0, 1'b1);
    collect("neg_zero");
  endtask

  task automatic test_saturation();
    push(32'h7FFFFFFF, 1'b1, 8'd2);
    send(32'h7FFFFFFF, 1'b0, 1'b0);
    send(32'h7FFFFFFF, 1'b0, 1'b1);
    collect("sat_pos");
    push(32'hFFFFFFFF, 1'b1, 8'd2);
    send(32'hFFFFFFFF, 1'b0, 1'b0);
    send(32'hFFFFFFFF, 1'b0, 1'b1);
    collect("sat_neg");
  endtask

  task automatic test_ovr();
    push(32'h00000002, 1'b1, 8'd2);
    send(32'h00000001, 1'b1, 1'b0);
    send(32'h00000001, 1'b0, 1'b1);
    collect("ovr_sticky");
    push(32'h00000005, 1'b0, 8'd1);
    send(32'h00000005, 1'b0, 1'b1);
    collect("ovr_clear");
  endtask

  task automatic test_backpressure();
    push(32'h00000030, 1'b0, 8'd2);
    send(32'h00000010, 1'b0, 1'b0);
    send(32'h00000020, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_valid = 1'b1; i_product = 32'h00000100; i_last = 1'b1;
      vectors++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'h30) begin
        miscompares++;
        $display("FAIL backpressure c%0d: valid=%b ready=%b res=%h want 1 0 00000030",
                 c, o_valid, o_ready, o_result);
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_last = 1'b0;
    collect("backpressure");
    push(32'h00000007, 1'b0, 8'd1);
    send(32'h00000007, 1'b0, 1'b1);
    collect("after_bp");
  endtask

  task automatic test_reset_mid();
    send(32'h00000500, 1'b0, 1'b0);
    send(32'h00000600, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (o_terms !== 8'd0 || o_ovr !== 1'b0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: terms=%0d ovr=%b valid=%b ready=%b want 0 0 0 1",
               o_terms, o_ovr, o_valid, o_ready);
    end
    push(32'h00001000, 1'b0, 8'd1);
    send(32'h00001000, 1'b0, 1'b1);
    collect("reset_mid");
  endtask

  task automatic test_term_sat();
    push(32'h0000012C, 1'b0, 8'd255);
    for (int k = 0; k < 300; k++) send(32'h00000001, 1'b0, (k == 299));
    collect("term_sat");
  endtask

  task automatic model_frame(input string name);
    push(model().res, model().ovr, model().terms);
    foreach (fb[i]) send(fb[i], 1'b0, (i == fb.size() - 1));
    collect(name);
  endtask

  task automatic test_back_to_back();
    fb.delete();
    for (int k = 0; k < 20; k++) fb.push_back(32'h7FFFFFFF);
    for (int k = 0; k < 20; k++) fb.push_back(32'hFFFFFFFF);
    model_frame("acc_clamp");
    for (int f = 0; f < 6; f++) begin
      fb.delete();
      for (int k = 0; k < 1 + int'($urandom_range(5)); k++)
        fb.push_back($urandom());
      model_frame($sformatf("rand%0d", f));
    end
  endtask

  initial begin
    test_reset();
    test_sign_change();
    test_negative();
    test_saturation();
    test_ovr();
    test_backpressure();
    test_reset_mid();
    test_term_sat();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
